// File: rtl/stall_controller_pkg.sv
// Shared definitions for the stall controller: mul/div FSM state encoding,
// default unit latencies and the countdown width.
package stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2
  } md_state_t;

  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 32;
  localparam int CNT_W       = 6;

endpackage

// File: rtl/stall_controller_md_latency_counter.sv
// Mul/div occupancy countdown: load a start value, decrement to zero, and
// report when the terminal count has been reached.
module md_latency_counter
  import stall_controller_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= '0;
    else if (i_load)
      r_count <= i_value;
    else if (i_dec && (r_count != '0))
      r_count <= r_count - 1'b1;
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/stall_controller.sv
// Pipeline stall/flush controller with a mul/div occupancy tracker.
// Optional macro STALL_PERF_CNT_EN adds a 32-bit stall_cycles counter port.
//
// state   | meaning
// IDLE    | mul/div unit free
// MUL_RUN | multiply in flight, counter holds remaining cycles - 1
// DIV_RUN | divide in flight, counter holds remaining cycles - 1
module stall_controller
  import stall_controller_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rt,
  input  logic [4:0]  if_id_rs,
  input  logic [4:0]  if_id_rt,
  input  logic        id_md_start,
  input  logic        id_md_is_div,
  input  logic        id_hilo_read,
  input  logic        ex_branch_taken,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        ctrl_bubble,
  output logic        if_id_flush,
  output logic        md_go,
  output logic        md_busy,
  output logic        md_done
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  md_state_t r_state, w_next_state;
  logic      w_cnt_zero;
  logic      w_load_use;
  logic      w_busy_blocking;
  logic      w_struct_stall;
  logic      w_stall;
  logic      w_launch;

  // Hazard detection; a unit on its final cycle no longer blocks ID.
  always_comb begin
    w_load_use      = id_ex_memread && (id_ex_rt != 5'd0) &&
                      ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
    w_busy_blocking = md_busy && !w_cnt_zero;
    w_struct_stall  = w_busy_blocking && (id_md_start || id_hilo_read);
    w_stall         = w_load_use || w_struct_stall;
    w_launch        = id_md_start && !w_busy_blocking && !w_load_use &&
                      !ex_branch_taken && !rst;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next_state;
  end

  // Next state plus pipeline control; a taken branch overrides any stall.
  always_comb begin
    w_next_state = r_state;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    ctrl_bubble  = 1'b0;
    if_id_flush  = 1'b0;
    md_busy      = (r_state != ST_IDLE);
    md_done      = (r_state != ST_IDLE) && w_cnt_zero;
    md_go        = w_launch;

    if (w_launch)
      w_next_state = id_md_is_div ? ST_DIV_RUN : ST_MUL_RUN;
    else if (md_done)
      w_next_state = ST_IDLE;

    if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      ctrl_bubble = 1'b1;
    end else if (w_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ctrl_bubble = 1'b1;
    end
  end

  md_latency_counter u_md_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_launch),
    .i_value (id_md_is_div ? DIV_LOAD : MUL_LOAD),
    .i_dec   (md_busy),
    .o_zero  (w_cnt_zero)
  );

`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  // Counts cycles where the pipeline is actually held (branch cycles excluded).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cycles <= '0;
    else if (w_stall && !ex_branch_taken)
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_stall_controller.sv
// Randomized scoreboard bench for stall_controller with directed scenarios.
module tb_stall_controller;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_ex_memread = 1'b0;
  logic [4:0] id_ex_rt = '0, if_id_rs = '0, if_id_rt = '0;
  logic id_md_start = 1'b0, id_md_is_div = 1'b0, id_hilo_read = 1'b0;
  logic ex_branch_taken = 1'b0;
  logic pc_write, if_id_write, ctrl_bubble, if_id_flush, md_go, md_busy, md_done;
  logic [31:0] sc_act;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles;
  assign sc_act = stall_cycles;
`else
  assign sc_act = '0;
`endif

  stall_controller #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_md_start(id_md_start), .id_md_is_div(id_md_is_div),
    .id_hilo_read(id_hilo_read), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .if_id_write(if_id_write), .ctrl_bubble(ctrl_bubble),
    .if_id_flush(if_id_flush), .md_go(md_go), .md_busy(md_busy), .md_done(md_done)
`ifdef STALL_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc, ifid, bub, fl, go, busy, done;
    logic [31:0] sc;
    logic [7:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: cycles remaining on the unit (0 = free) and stall count.
  int left_m = 0;
  int sc_m = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v, input logic [7:0] tag);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s tag=%0d actual=%0h required=%0h at %0t", nm, tag, act, exp_v, $time);
    end
  endtask

  task automatic step(input logic r, input logic mr, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic st, input logic dv, input logic hl,
                      input logic br, input logic [7:0] tag);
    logic lu, busy, done, stall, launch;
    exp_t e;
    @(posedge clk); #1;
    rst = r; id_ex_memread = mr; id_ex_rt = ert; if_id_rs = rs; if_id_rt = rt;
    id_md_start = st; id_md_is_div = dv; id_hilo_read = hl; ex_branch_taken = br;

    lu     = mr && (ert != 0) && (ert == rs || ert == rt);
    busy   = !r && left_m > 0;
    done   = !r && left_m == 1;
    stall  = lu || (busy && !done && (st || hl));
    launch = !r && (!busy || done) && st && !lu && !br;
    e.tag  = tag;
    if (br)         {e.pc, e.ifid, e.bub, e.fl} = 4'b1111;
    else if (stall) {e.pc, e.ifid, e.bub, e.fl} = 4'b0010;
    else            {e.pc, e.ifid, e.bub, e.fl} = 4'b1100;
    e.go = launch; e.busy = busy; e.done = done;
    e.sc = r ? 32'd0 : 32'(sc_m);
    exp_q.push_back(e);

    if (r) begin
      left_m = 0; sc_m = 0;
    end else begin
      if (stall && !br) sc_m++;
      if (launch) left_m = dv ? DIV_LAT : MUL_LAT;
      else if (left_m > 0) left_m--;
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectation mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc_write",    32'(pc_write),    32'(e.pc),   e.tag);
      chk("if_id_write", 32'(if_id_write), 32'(e.ifid), e.tag);
      chk("ctrl_bubble", 32'(ctrl_bubble), 32'(e.bub),  e.tag);
      chk("if_id_flush", 32'(if_id_flush), 32'(e.fl),   e.tag);
      chk("md_go",       32'(md_go),       32'(e.go),   e.tag);
      chk("md_busy",     32'(md_busy),     32'(e.busy), e.tag);
      chk("md_done",     32'(md_done),     32'(e.done), e.tag);
`ifdef STALL_PERF_CNT_EN
      chk("stall_cycles", sc_act, e.sc, e.tag);
`endif
    end
  end

  int go_seen;
  int done_seen;

  initial begin
    // Reset held, then released
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 5'd8, 5'd8, 0, 1, 0, 0, 0, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    // Load-use: LW $8 / ADD $9,$8,$1, then proceeds
    step(0, 1, 5'd8, 5'd8, 5'd1, 0, 0, 0, 0, 10);
    step(0, 0, 0, 5'd8, 5'd1, 0, 0, 0, 0, 11);
    // Load of $0 never stalls
    step(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 12);
    // MULT then MFLO: 3 stalls, proceeds on done cycle
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 20);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 21);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 22);
    // DIV with branch while MFHI in ID; divide continues to completion
    step(0, 0, 0, 0, 0, 1, 1, 0, 0, 30);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 31);
    for (int i = 0; i < 31; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 32);
    // Back-to-back: MULT in done cycle of another MULT
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 40);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 41);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 42);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 43);
    // Reset in the middle of a divide: no done afterwards
    step(0, 0, 0, 0, 0, 1, 1, 0, 0, 50);
    for (int i = 0; i < 21; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 51);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 52);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 53);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), 100);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stall_controller.md
STALL_CONTROLLER -- requirements
Module: stall_controller

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, meaning MULT/MULTU occupancy in cycles (range 1-63).
REQ-002 SHALL have parameter DIV_LAT, default 32, meaning DIV/DIVU occupancy in cycles (range 1-63).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 id_ex_memread  in  1  EX-stage instruction is a load.
REQ-006 id_ex_rt  in  5  load destination register.
REQ-007 if_id_rs, if_id_rt  in  5 each  ID-stage source registers.
REQ-008 id_md_start  in  1  ID-stage instruction is MULT/MULTU/DIV/DIVU.
REQ-009 id_md_is_div  in  1  qualifies id_md_start: 1 = divide.
REQ-010 id_hilo_read  in  1  ID-stage instruction is MFHI/MFLO.
REQ-011 ex_branch_taken  in  1  EX-stage branch/jump resolved taken.
REQ-012 pc_write, if_id_write  out  1 each  PC / IF-ID register enables.
REQ-013 ctrl_bubble  out  1  forces ID/EX control fields to zero.
REQ-014 if_id_flush  out  1  clears IF/ID to NOP.
REQ-015 md_go  out  1  one-cycle launch pulse to mul/div unit; md_busy  out  1; md_done  out  1  one-cycle HI/LO write strobe.

Function
REQ-016 Load-use hazard (combinational) SHALL assert when id_ex_memread=1, id_ex_rt!=0, and id_ex_rt equals if_id_rs or if_id_rt.
REQ-017 FSM states SHALL be IDLE, MUL_RUN, DIV_RUN; md_busy=1 exactly in MUL_RUN/DIV_RUN.
REQ-018 IDLE -> MUL_RUN/DIV_RUN SHALL occur when id_md_start=1 and no load-use hazard and ex_branch_taken=0; md_go pulses that cycle; counter loads MUL_LAT-1 or DIV_LAT-1.
REQ-019 In RUN states counter SHALL decrement each cycle; at count 0, md_done pulses and FSM returns to IDLE next edge.
REQ-020 Structural stall SHALL assert when md_busy=1 and (id_md_start=1 or id_hilo_read=1) in ID.
REQ-021 Stall (load-use or structural) SHALL drive pc_write=0, if_id_write=0, ctrl_bubble=1, if_id_flush=0.
REQ-022 ex_branch_taken SHALL take priority over any stall: pc_write=1, if_id_write=1, if_id_flush=1, ctrl_bubble=1, md_go=0.
REQ-023 A running mul/div SHALL NOT be aborted by ex_branch_taken; it completes normally.
REQ-024 With no stall and no branch: pc_write=1, if_id_write=1, ctrl_bubble=0, if_id_flush=0.
REQ-025 MFHI/MFLO on the same cycle as md_done SHALL NOT stall (md_busy still 1 is masked when counter=0).
REQ-026 Back-to-back mul/div: a new id_md_start in the md_done cycle SHALL launch immediately (RUN -> RUN, md_go=1).
REQ-027 Stall outputs SHALL be combinational from inputs and registered state; zero added latency.

Reset
REQ-028 rst SHALL asynchronously force FSM=IDLE, counter=0, md_busy=0, md_go=0, md_done=0.
REQ-029 During and after reset, pc_write=1, if_id_write=1, ctrl_bubble=0, if_id_flush=0 unless inputs indicate hazard.
REQ-030 Reset mid-operation SHALL abandon the operation with no md_done pulse.

Configuration
REQ-031 Macro STALL_PERF_CNT_EN: when defined, SHALL add output stall_cycles (32-bit), incrementing each cycle stall of REQ-021 is active, wrapping at 2^32-1 to 0, cleared by rst; when undefined, port and counter SHALL be absent.

Structure
REQ-032 Shared package SHALL hold FSM state encoding (2-bit: IDLE=0, MUL_RUN=1, DIV_RUN=2) and default latency constants.
REQ-033 Countdown SHALL be a sub-module md_latency_counter (load, value, decrement, zero flag).

Verification
REQ-034 LW $8 in EX, ADD $9,$8,$1 in ID -> one cycle pc_write=0, if_id_write=0, ctrl_bubble=1.
REQ-035 LW $0 in EX, ID reads $0 -> no stall.
REQ-036 MULT issued, MFLO next cycle, MUL_LAT=4 -> md_go one cycle, 3 stall cycles, md_done in 4th cycle, MFLO proceeds that cycle.
REQ-037 DIV running, ex_branch_taken=1 while MFHI in ID -> if_id_flush=1, pc_write=1, divide continues, md_done after 32 cycles total.
REQ-038 rst asserted at DIV count 10 -> md_busy=0 immediately, no md_done, pc_write=1.
REQ-039 With STALL_PERF_CNT_EN, REQ-036 sequence -> stall_cycles=3.
